// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: holds the PC, issues one memory request per
// instruction, registers the returned word and selects the next PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] PCBranch,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } state_t;

  state_t      state_q, state_d;
  logic        load_instr;
  logic        leave_hold;
  logic        advance_pc;
  logic [31:0] sel_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    load_instr = 1'b0;
    leave_hold = 1'b0;
    advance_pc = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          leave_hold = 1'b1;
          if (Instr == HALT_WORD) begin
            state_d = HALT;
          end else begin
            advance_pc = 1'b1;
            state_d    = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Jump outranks branch; the jump target is word-aligned by construction.
  always_comb begin
    sel_pc = PCPlus4;
    if (Jump) begin
      sel_pc = {PCPlus4[31:28], Instr[25:0], 2'b00};
    end else if (PCSrc) begin
      sel_pc = PCBranch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= RESET_PC;
      Instr        <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (load_instr) begin
        Instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (leave_hold) begin
        instr_valid <= 1'b0;
      end
      if (advance_pc) begin
        PC <= {sel_pc[31:2], 2'b00};
        if (sel_pc[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end
      end
    end
  end

  assign imem_addr = PC;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written
// reset/wrap sequences and randomized fetch traffic against a reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] HALT_W = 32'h0000_000C;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] PCBranch;
  logic        PCSrc;
  logic        Jump;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        halted;
  logic        misalign_err;

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(HALT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .PCBranch    (PCBranch),
    .PCSrc       (PCSrc),
    .Jump        (Jump),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .halted      (halted),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state: architectural PC, sticky misalign flag, halt flag.
  logic [31:0] m_pc;
  bit          m_mis;
  bit          m_halted;

  typedef struct {
    logic [31:0] word;
    bit          jmp;
    bit          src;
    logic [31:0] br;
    int unsigned waits;
    int unsigned stalls;
    logic [31:0] exp_pc;
    bit          exp_mis;
    bit          exp_halt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] word, input bit jmp,
                                             input bit src, input logic [31:0] br,
                                             input logic [31:0] p4);
    if (jmp) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
    if (src) return br;
    return p4;
  endfunction

  // One complete instruction, entered at a falling edge with the DUT in REQ.
  task automatic do_fetch(input logic [31:0] word, input bit jmp, input bit src,
                          input logic [31:0] br, input logic [31:0] p4,
                          input int unsigned waits, input int unsigned stalls);
    logic [31:0] nxt;
    chk("req_start", imem_req, 1'b1);
    chk("addr_start", imem_addr, m_pc);
    for (int unsigned i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("req_wait", imem_req, 1'b1);
      chk("pc_wait", PC, m_pc);
      chk("valid_wait", instr_valid, 1'b0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    Jump       = 1'($urandom);
    PCSrc      = 1'($urandom);
    PCBranch   = $urandom;
    PCPlus4    = $urandom;
    @(negedge clk);
    chk("valid_load", instr_valid, 1'b1);
    chk("instr_load", Instr, word);
    chk("req_hold", imem_req, 1'b0);
    chk("pc_load", PC, m_pc);
    for (int unsigned i = 0; i < stalls; i++) begin
      stall      = 1'b1;
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      Jump       = 1'($urandom);
      PCSrc      = 1'($urandom);
      PCBranch   = $urandom;
      @(negedge clk);
      chk("pc_stall", PC, m_pc);
      chk("instr_stall", Instr, word);
      chk("valid_stall", instr_valid, 1'b1);
      chk("req_stall", imem_req, 1'b0);
    end
    stall      = 1'b0;
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    Jump       = jmp;
    PCSrc      = src;
    PCBranch   = br;
    PCPlus4    = p4;
    @(negedge clk);
    if (word == HALT_W) begin
      m_halted = 1'b1;
    end else begin
      nxt = model_next(word, jmp, src, br, p4);
      if (nxt % 4 != 0) m_mis = 1'b1;
      m_pc = nxt & ~32'h3;
    end
    chk("pc_next", PC, m_pc);
    chk("misalign", misalign_err, m_mis);
    chk("halted", halted, m_halted);
    chk("valid_clear", instr_valid, 1'b0);
    chk("req_next", imem_req, !m_halted);
    imem_ready = 1'b0;
    Jump       = 1'b0;
    PCSrc      = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, PC, 32'h0);
    chk({tag, "_instr"}, Instr, 32'h0);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_mis"}, misalign_err, 1'b0);
  endtask

  // Release reset at a falling edge; the next rising edge leaves IDLE for REQ.
  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    chk("req_after_release", imem_req, 1'b0);
    @(negedge clk);
    chk("req_first", imem_req, 1'b1);
    chk("addr_first", imem_addr, 32'h0);
    chk("valid_first", instr_valid, 1'b0);
    m_pc     = 32'h0;
    m_mis    = 1'b0;
    m_halted = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, br;
    bit          j, s;

    tbl[0]  = '{32'h0000_0020, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_0004, 1'b0, 1'b0};
    tbl[1]  = '{32'h1111_1111, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_0008, 1'b0, 1'b0};
    tbl[2]  = '{32'h2222_2222, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_000C, 1'b0, 1'b0};
    tbl[3]  = '{32'h3333_3333, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_0010, 1'b0, 1'b0};
    tbl[4]  = '{32'h4444_4444, 1'b0, 1'b0, 32'h0,         3, 0, 32'h0000_0014, 1'b0, 1'b0};
    tbl[5]  = '{32'h0800_0040, 1'b1, 1'b1, 32'h200,       0, 0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[6]  = '{32'h5555_5555, 1'b0, 1'b1, 32'h40,        1, 5, 32'h0000_0040, 1'b0, 1'b0};
    tbl[7]  = '{32'h6666_6666, 1'b0, 1'b0, 32'h0,         0, 1, 32'h0000_0044, 1'b0, 1'b0};
    tbl[8]  = '{32'h7777_7777, 1'b0, 1'b1, 32'h22,        0, 0, 32'h0000_0020, 1'b1, 1'b0};
    tbl[9]  = '{32'h8888_8888, 1'b0, 1'b0, 32'h0,         2, 2, 32'h0000_0024, 1'b1, 1'b0};
    tbl[10] = '{32'h0BFF_FFFF, 1'b1, 1'b0, 32'h0,         0, 0, 32'h0FFF_FFFC, 1'b1, 1'b0};
    tbl[11] = '{32'h9999_9999, 1'b0, 1'b0, 32'h0,         0, 0, 32'h1000_0000, 1'b1, 1'b0};
    tbl[12] = '{32'h0800_0001, 1'b1, 1'b0, 32'h0,         0, 0, 32'h1000_0004, 1'b1, 1'b0};
    tbl[13] = '{HALT_W,        1'b0, 1'b1, 32'h300,       0, 2, 32'h1000_0004, 1'b1, 1'b1};

    rst_n      = 1'b0;
    stall      = 1'b0;
    Jump       = 1'b0;
    PCSrc      = 1'b0;
    PCBranch   = '0;
    PCPlus4    = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    #1;
    check_reset_values("rst0");
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst0_held");
    release_reset();

    foreach (tbl[i]) begin
      do_fetch(tbl[i].word, tbl[i].jmp, tbl[i].src, tbl[i].br, m_pc + 32'd4,
               tbl[i].waits, tbl[i].stalls);
      chk("tbl_pc", PC, tbl[i].exp_pc);
      chk("tbl_mis", misalign_err, tbl[i].exp_mis);
      chk("tbl_halt", halted, tbl[i].exp_halt);
    end

    // HALT is absorbing: memory responses and control inputs are ignored.
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      Jump       = 1'($urandom);
      PCSrc      = 1'($urandom);
      @(negedge clk);
      chk("halt_req", imem_req, 1'b0);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_flag", halted, 1'b1);
      chk("halt_pc", PC, 32'h1000_0004);
      chk("halt_instr", Instr, HALT_W);
    end
    imem_ready = 1'b0;

    // Asynchronous reset out of HALT clears everything without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("rst_halt");
    @(negedge clk);
    release_reset();

    // PC wrap through 0xFFFF_FFFC, then branch to 0x40.
    do_fetch(32'hAAAA_0000, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h4, 0, 0);
    do_fetch(32'hAAAA_0001, 1'b0, 1'b0, 32'h0, m_pc + 32'd4, 0, 0);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_mis", misalign_err, 1'b0);
    do_fetch(32'hAAAA_0002, 1'b0, 1'b1, 32'h40, 32'h4, 1, 0);

    // Reset mid-REQ at 0x40 with a memory response pulsed during reset.
    chk("preR_pc", PC, 32'h40);
    chk("preR_req", imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("rst_req");
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst_req_held");
    imem_ready = 1'b0;
    release_reset();
    chk("instr_discard", Instr, 32'h0);

    // Randomized traffic against the reference model, ending in a halt.
    for (int n = 0; n < 80; n++) begin
      w = $urandom;
      if (w == HALT_W) w = w ^ 32'h1;
      j  = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 2) == 0);
      br = $urandom & ~32'h3;
      if ($urandom_range(0, 7) == 0) br = br | 32'($urandom_range(1, 3));
      do_fetch(w, j, s, br, m_pc + 32'd4, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    do_fetch(HALT_W, 1'b1, 1'b1, 32'h1234, m_pc + 32'd4, 1, 1);
    @(negedge clk);
    chk("rand_halt_req", imem_req, 1'b0);
    chk("rand_halt_pc", PC, m_pc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
